// File: rtl/seq_pkg.sv
// seq_pkg: state encoding shared by the lab's serial transmitter and detector FSMs
package seq_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_t;
endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: parallel load handshake plus serial output of the pattern transmitter
interface seq_pattern_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_in;
  logic load_valid;
  logic load_ready;
  logic bit_out;
  logic bit_valid;
  logic busy;
  logic done;
  modport master(output data_in, load_valid, input load_ready, bit_out, bit_valid, busy, done);
  modport slave(input data_in, load_valid, output load_ready, bit_out, bit_valid, busy, done);
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serializer with valid/ready load and a zero-held inter-word gap
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP = 2
) (
  input logic clk,
  input logic reset,
  seq_pattern_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  localparam int GAP_INIT = GAP > 0 ? GAP - 1 : 0;
  state_t state, state_nx;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nx;
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE: state_nx = bus.load_valid ? S_SHIFT : S_IDLE;
      S_SHIFT: state_nx = bit_cnt != '0 ? S_SHIFT : (GAP == 0 ? S_IDLE : S_GAP);
      S_GAP: state_nx = gap_cnt != '0 ? S_GAP : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  // counters saturate at zero so the last-bit/last-gap cycle never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.load_valid) begin
          shift_reg <= bus.data_in;
          bit_cnt <= CW'(WIDTH - 1);
        end
        S_SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
          else gap_cnt <= GW'(GAP_INIT);
        end
        S_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end
  always_comb begin
    bus.load_ready = state == S_IDLE;
    bus.busy = state == S_SHIFT || state == S_GAP;
    bus.bit_valid = state == S_SHIFT;
    bus.bit_out = state == S_SHIFT && shift_reg[WIDTH-1];
    bus.done = state == S_SHIFT && bit_cnt == '0;
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench for the serial pattern transmitter (GAP=2 and GAP=0 instances)
module tb_seq_pattern_tx;
  logic clk = 0;
  logic reset;
  int errors = 0;
  int checks = 0;
  logic exp_q[$];
  logic [1:0] det_s;
  logic det;
  seq_pattern_tx_if #(.WIDTH(8)) bus();
  seq_pattern_tx_if #(.WIDTH(8)) bus0();
  seq_pattern_tx #(.WIDTH(8), .GAP(2)) dut(.clk(clk), .reset(reset), .bus(bus));
  seq_pattern_tx #(.WIDTH(8), .GAP(0)) dut0(.clk(clk), .reset(reset), .bus(bus0));
  always #5 clk = ~clk;
  // reference "11" Moore detector fed from the serial line
  always @(posedge clk) det_s <= reset ? 2'd0 : (bus.bit_out ? (det_s == 2'd0 ? 2'd1 : 2'd2) : 2'd0);
  assign det = det_s == 2'd2;
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  task automatic test_reset();
    logic [4:0] o;
    reset = 1;
    repeat (2) @(negedge clk);
    o = {bus.load_ready, bus.bit_out, bus.bit_valid, bus.busy, bus.done};
    checks++;
    if (o !== 5'b10000) begin errors++; $display("FAIL reset_state: got %b want 10000", o); end
    reset = 0;
    bus.data_in = 8'hFF;
    bus.load_valid = 1;
    @(negedge clk);
    bus.load_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if ({bus.bit_valid, bus.bit_out} !== 2'b11) begin errors++; $display("FAIL reset_preshift cycle %0d: got %b want 11", k, {bus.bit_valid, bus.bit_out}); end
      @(negedge clk);
    end
    reset = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      o = {bus.load_ready, bus.bit_out, bus.bit_valid, bus.busy, bus.done};
      checks++;
      if (o !== 5'b10000) begin errors++; $display("FAIL reset_midword %0d: got %b want 10000", k, o); end
    end
    reset = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      o = {bus.load_ready, bus.bit_out, bus.bit_valid, bus.busy, bus.done};
      checks++;
      if (o !== 5'b10000) begin errors++; $display("FAIL reset_abandon %0d: got %b want 10000", k, o); end
    end
    reset = 1;
    bus.data_in = 8'hA5;
    bus.load_valid = 1;
    @(negedge clk);
    reset = 0;
    bus.load_valid = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus.load_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL reset_wins %0d: got %b want 10", k, {bus.load_ready, bus.busy}); end
      @(negedge clk);
    end
  endtask
  task automatic test_basic();
    logic [7:0] w = 8'hB4;
    logic [3:0] ctl, want;
    logic b;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    bus.data_in = w;
    bus.load_valid = 1;
    @(negedge clk);
    bus.load_valid = 0;
    for (int k = 1; k <= 12; k++) begin
      ctl = {bus.load_ready, bus.busy, bus.bit_valid, bus.done};
      want = {k >= 11, k <= 10, k <= 8, k == 8};
      checks++;
      if (ctl !== want) begin errors++; $display("FAIL basic_ctl cycle %0d: got %b want %b", k, ctl, want); end
      checks++;
      if (bus.bit_valid && exp_q.size() == 0) begin errors++; $display("FAIL basic_bit cycle %0d: unexpected bit %b", k, bus.bit_out); end
      else if (bus.bit_valid) begin
        b = exp_q.pop_front();
        if (bus.bit_out !== b) begin errors++; $display("FAIL basic_bit cycle %0d: got %b want %b", k, bus.bit_out, b); end
      end else if (bus.bit_out !== 1'b0) begin errors++; $display("FAIL basic_line cycle %0d: got %b want 0", k, bus.bit_out); end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] w1 = 8'h81, w2 = 8'h7E;
    logic [3:0] ctl, want;
    logic b;
    int gap_zeros = 0;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w1[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w2[i]);
    bus.data_in = w1;
    bus.load_valid = 1;
    @(negedge clk);
    bus.data_in = w2;
    for (int k = 1; k <= 22; k++) begin
      ctl = {bus.load_ready, bus.busy, bus.bit_valid, bus.done};
      want = {k == 11 || k == 22, !(k == 11 || k == 22), k <= 8 || (k >= 12 && k <= 19), k == 8 || k == 19};
      checks++;
      if (ctl !== want) begin errors++; $display("FAIL b2b_ctl cycle %0d: got %b want %b", k, ctl, want); end
      if (k > 8 && k < 12 && bus.busy && !bus.bit_valid && !bus.bit_out) gap_zeros++;
      if (bus.bit_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_bit cycle %0d: unexpected bit %b", k, bus.bit_out); end
        else begin
          b = exp_q.pop_front();
          if (bus.bit_out !== b) begin errors++; $display("FAIL b2b_bit cycle %0d: got %b want %b", k, bus.bit_out, b); end
        end
      end
      if (k == 12) bus.load_valid = 0;
      @(negedge clk);
    end
    checks++;
    if (gap_zeros != 2) begin errors++; $display("FAIL b2b_gap: got %0d gap zeros want 2", gap_zeros); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask
  task automatic test_ignored_load();
    logic [3:0] ctl, want;
    logic b;
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    bus.data_in = 8'hFF;
    bus.load_valid = 1;
    @(negedge clk);
    bus.load_valid = 0;
    for (int k = 1; k <= 14; k++) begin
      ctl = {bus.load_ready, bus.busy, bus.bit_valid, bus.done};
      want = {k >= 11, k <= 10, k <= 8, k == 8};
      checks++;
      if (ctl !== want) begin errors++; $display("FAIL ignore_ctl cycle %0d: got %b want %b", k, ctl, want); end
      if (bus.bit_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ignore_bit cycle %0d: unexpected bit %b", k, bus.bit_out); end
        else begin
          b = exp_q.pop_front();
          if (bus.bit_out !== b) begin errors++; $display("FAIL ignore_bit cycle %0d: got %b want %b", k, bus.bit_out, b); end
        end
      end
      if (k == 4) begin bus.data_in = 8'h00; bus.load_valid = 1; end
      if (k == 5) bus.load_valid = 0;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ignore_drain: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask
  task automatic test_gap0();
    logic [7:0] w1 = 8'h03, w2 = 8'h80;
    logic [3:0] ctl, want;
    logic b;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w1[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w2[i]);
    bus0.data_in = w1;
    bus0.load_valid = 1;
    @(negedge clk);
    bus0.load_valid = 0;
    for (int k = 1; k <= 18; k++) begin
      ctl = {bus0.load_ready, bus0.busy, bus0.bit_valid, bus0.done};
      want = {k == 9 || k == 18, !(k == 9 || k == 18), k <= 8 || (k >= 10 && k <= 17), k == 8 || k == 17};
      checks++;
      if (ctl !== want) begin errors++; $display("FAIL gap0_ctl cycle %0d: got %b want %b", k, ctl, want); end
      if (bus0.bit_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL gap0_bit cycle %0d: unexpected bit %b", k, bus0.bit_out); end
        else begin
          b = exp_q.pop_front();
          if (bus0.bit_out !== b) begin errors++; $display("FAIL gap0_bit cycle %0d: got %b want %b", k, bus0.bit_out, b); end
        end
      end
      if (k == 9) begin bus0.data_in = w2; bus0.load_valid = 1; end
      if (k == 10) bus0.load_valid = 0;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL gap0_drain: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask
  task automatic test_detector();
    int hits = 0;
    bus.data_in = 8'hB4;
    bus.load_valid = 1;
    @(negedge clk);
    bus.load_valid = 0;
    for (int k = 1; k <= 13; k++) begin
      if (det) hits++;
      if (k == 5 || k == 9 || k == 10) begin
        checks++;
        if (det !== (k == 5)) begin errors++; $display("FAIL detector cycle %0d: got %b want %b", k, det, k == 5); end
      end
      @(negedge clk);
    end
    checks++;
    if (hits != 1) begin errors++; $display("FAIL detector_hits: got %0d want 1", hits); end
  endtask
  initial begin
    bus.data_in = '0;
    bus.load_valid = 0;
    bus0.data_in = '0;
    bus0.load_valid = 0;
    reset = 1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_load();
    test_gap0();
    test_detector();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
